// File: rtl/hc_sr04_ranger.sv
// HC-SR04 ultrasonic ranger: fires a trigger pulse, times the echo in microseconds
// and reports the distance in whole centimetres (16'hFFFF when no valid echo).
module hc_sr04_ranger #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int TRIG_US      = 10,
  parameter int ECHO_WAIT_US = 30_000,
  parameter int MAX_ECHO_US  = 25_000,
  parameter int COOLDOWN_US  = 60_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] data,
  output logic        data_available,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CYC_US  = CLK_FREQ_HZ / 1_000_000;
  localparam int PRESC_W = (CYC_US > 1) ? $clog2(CYC_US) : 1;
  localparam int MAX_AB  = (TRIG_US > ECHO_WAIT_US) ? TRIG_US : ECHO_WAIT_US;
  localparam int MAX_CD  = (MAX_ECHO_US > COOLDOWN_US) ? MAX_ECHO_US : COOLDOWN_US;
  localparam int MAX_US  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int US_W    = $clog2(MAX_US + 2);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYC_US - 1);
  localparam logic [US_W-1:0]    TRIG_LAST  = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]    WAIT_LAST  = US_W'(ECHO_WAIT_US - 1);
  localparam logic [US_W-1:0]    ECHO_LAST  = US_W'(MAX_ECHO_US - 1);
  localparam logic [US_W-1:0]    COOL_LAST  = US_W'(COOLDOWN_US - 1);
  localparam logic [5:0]         SUB_LAST   = 6'd57;
  localparam logic [15:0]        CM_SAT     = 16'hFFFE;
  localparam logic [15:0]        ERR_CODE   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_DONE,
    S_COOLDOWN
  } state_t;

  state_t             state_reg;
  logic               echo_meta_reg;
  logic               echo_sync_reg;
  logic               echo_prev_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [US_W-1:0]    us_cnt_reg;
  logic [5:0]         sub_cnt_reg;
  logic [15:0]        cm_cnt_reg;
  logic               err_reg;
  logic               trig_reg;
  logic [15:0]        data_reg;
  logic               data_available_reg;
  logic               busy_reg;
  logic               timeout_err_reg;

  logic us_tick;
  logic echo_rise;
  logic echo_fall;

  assign us_tick   = (presc_reg == PRESC_LAST);
  assign echo_rise = echo_sync_reg & ~echo_prev_reg;
  assign echo_fall = ~echo_sync_reg & echo_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= S_IDLE;
      echo_meta_reg      <= 1'b0;
      echo_sync_reg      <= 1'b0;
      echo_prev_reg      <= 1'b0;
      presc_reg          <= '0;
      us_cnt_reg         <= '0;
      sub_cnt_reg        <= '0;
      cm_cnt_reg         <= '0;
      err_reg            <= 1'b0;
      trig_reg           <= 1'b0;
      data_reg           <= '0;
      data_available_reg <= 1'b0;
      busy_reg           <= 1'b0;
      timeout_err_reg    <= 1'b0;
    end else begin
      echo_meta_reg <= echo;
      echo_sync_reg <= echo_meta_reg;
      echo_prev_reg <= echo_sync_reg;

      // Free-running prescaler; every state transition below restarts it.
      presc_reg <= us_tick ? '0 : presc_reg + 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg          <= S_TRIG;
            trig_reg           <= 1'b1;
            busy_reg           <= 1'b1;
            data_available_reg <= 1'b0;
            timeout_err_reg    <= 1'b0;
            err_reg            <= 1'b0;
            us_cnt_reg         <= '0;
            sub_cnt_reg        <= '0;
            cm_cnt_reg         <= '0;
            presc_reg          <= '0;
          end
        end

        S_TRIG: begin
          if (us_tick) begin
            if (us_cnt_reg == TRIG_LAST) begin
              state_reg  <= S_WAIT_ECHO;
              trig_reg   <= 1'b0;
              us_cnt_reg <= '0;
              presc_reg  <= '0;
            end else begin
              us_cnt_reg <= us_cnt_reg + 1'b1;
            end
          end
        end

        S_WAIT_ECHO: begin
          if (echo_rise) begin
            state_reg  <= S_MEASURE;
            us_cnt_reg <= '0;
            presc_reg  <= '0;
          end else if (us_tick) begin
            if (us_cnt_reg == WAIT_LAST) begin
              state_reg <= S_DONE;
              err_reg   <= 1'b1;
              presc_reg <= '0;
            end else begin
              us_cnt_reg <= us_cnt_reg + 1'b1;
            end
          end
        end

        S_MEASURE: begin
          // A tick coinciding with the falling edge still counts toward the result.
          if (us_tick) begin
            us_cnt_reg <= us_cnt_reg + 1'b1;
            if (sub_cnt_reg == SUB_LAST) begin
              sub_cnt_reg <= '0;
              if (cm_cnt_reg != CM_SAT) begin
                cm_cnt_reg <= cm_cnt_reg + 1'b1;
              end
            end else begin
              sub_cnt_reg <= sub_cnt_reg + 1'b1;
            end
          end
          if (echo_fall) begin
            state_reg <= S_DONE;
            presc_reg <= '0;
          end else if (us_tick && (us_cnt_reg == ECHO_LAST)) begin
            state_reg <= S_DONE;
            err_reg   <= 1'b1;
            presc_reg <= '0;
          end
        end

        S_DONE: begin
          data_reg           <= err_reg ? ERR_CODE : cm_cnt_reg;
          timeout_err_reg    <= err_reg;
          data_available_reg <= 1'b1;
          state_reg          <= S_COOLDOWN;
          us_cnt_reg         <= '0;
          presc_reg          <= '0;
        end

        S_COOLDOWN: begin
          if (us_tick) begin
            if (us_cnt_reg == COOL_LAST) begin
              state_reg  <= S_IDLE;
              busy_reg   <= 1'b0;
              us_cnt_reg <= '0;
              presc_reg  <= '0;
            end else begin
              us_cnt_reg <= us_cnt_reg + 1'b1;
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
          trig_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign trig           = trig_reg;
  assign data           = data_reg;
  assign data_available = data_available_reg;
  assign busy           = busy_reg;
  assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_hc_sr04_ranger.sv
// Scoreboard bench for hc_sr04_ranger with time-scaled parameters (2 clocks per us).
module tb_hc_sr04_ranger;

  localparam int CLK_HZ  = 2_000_000;
  localparam int C       = CLK_HZ / 1_000_000;
  localparam int TRIG_US = 10;
  localparam int WAIT_US = 300;
  localparam int MAX_US  = 700;
  localparam int COOL_US = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        echo;
  logic        trig;
  logic [15:0] data;
  logic        data_available;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  int trig_pulses = 0;
  int trig_run = 0;
  logic trig_d = 1'b0;
  logic da_d = 1'b0;

  always #5 clk = ~clk;

  hc_sr04_ranger #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TRIG_US     (TRIG_US),
    .ECHO_WAIT_US(WAIT_US),
    .MAX_ECHO_US (MAX_US),
    .COOLDOWN_US (COOL_US)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .echo          (echo),
    .trig          (trig),
    .data          (data),
    .data_available(data_available),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cm_of(input int us);
    return (us > MAX_US) ? 16'hFFFF : 16'(us / 58);
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return trig;
      1:       return busy;
      default: return data_available;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_for(input string tag, input int sel, input logic lvl, input int budget);
    int n = 0;
    while (sig(sel) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel) !== lvl) chk(tag, 32'(sig(sel)), 32'(lvl));
  endtask

  task automatic measure(input int delay_us, input int echo_us);
    exp_q.push_back({echo_us > MAX_US, cm_of(echo_us)});
    pulse_start();
    wait_for("trig_rise", 0, 1'b1, 10);
    wait_for("trig_fall", 0, 1'b0, TRIG_US * C + 10);
    tick(delay_us * C);
    echo = 1'b1;
    tick(echo_us * C);
    echo = 1'b0;
    wait_for("idle", 1, 1'b0, (MAX_US + COOL_US + 50) * C);
    chk("sb_drain", exp_q.size(), 0);
    $display("measure echo_us=%0d data=%0h terr=%0b", echo_us, data, timeout_err);
  endtask

  // Trigger pulse width monitor.
  initial forever begin
    @(negedge clk);
    if (trig) begin
      trig_run++;
    end else if (trig_d) begin
      trig_pulses++;
      chk("trig_width", trig_run, TRIG_US * C);
      trig_run = 0;
    end
    trig_d = trig;
  end

  // Scoreboard: compare each new result against the oldest expectation.
  initial forever begin
    logic [16:0] e;
    @(negedge clk);
    if (data_available && !da_d) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", data, e[15:0]);
        chk("sb_terr", timeout_err, e[16]);
      end
    end
    da_d = data_available;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    rst   = 1'b1;
    start = 1'b0;
    echo  = 1'b0;
    tick(3);
    chk("rst_trig", trig, 0);
    chk("rst_data", data, 0);
    chk("rst_da", data_available, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    tick(3);

    // Nominal 580 us echo -> 10 cm.
    measure(200, 580);
    chk("da_hold", data_available, 1);
    chk("terr_ok", timeout_err, 0);
    chk("data_10", data, 16'h000A);

    // Centimetre boundaries and longest valid echo.
    measure(50, 57);
    measure(50, 58);
    measure(50, 464);
    measure(50, 696);

    // No echo at all: timeout in WAIT_ECHO after WAIT_US microseconds.
    exp_q.push_back({1'b1, 16'hFFFF});
    pulse_start();
    wait_for("trig_rise", 0, 1'b1, 10);
    wait_for("trig_fall", 0, 1'b0, TRIG_US * C + 10);
    n = 0;
    while (!data_available && n < 2 * WAIT_US * C) begin
      @(negedge clk);
      n++;
    end
    chk("wait_tmo_lat", n, WAIT_US * C + 1);
    wait_for("idle", 1, 1'b0, (COOL_US + 10) * C);
    chk("sb_drain", exp_q.size(), 0);
    $display("no_echo data=%0h terr=%0b cycles=%0d", data, timeout_err, n);

    // Echo stuck high beyond MAX_US.
    measure(50, 800);

    // Starts during TRIG, MEASURE and COOLDOWN are dropped.
    p0 = trig_pulses;
    exp_q.push_back({1'b0, cm_of(116)});
    pulse_start();
    wait_for("trig_rise", 0, 1'b1, 10);
    tick(3);
    pulse_start();
    wait_for("trig_fall", 0, 1'b0, TRIG_US * C + 10);
    tick(100 * C);
    echo = 1'b1;
    tick(50 * C);
    pulse_start();
    tick(66 * C - 1);
    echo = 1'b0;
    wait_for("da_rise", 2, 1'b1, 20);
    tick(5);
    pulse_start();
    wait_for("idle", 1, 1'b0, (COOL_US + 10) * C);
    tick(1);
    chk("one_trig", trig_pulses - p0, 1);
    $display("ignore_starts data=%0h pulses=%0d", data, trig_pulses - p0);

    // Start right after returning to IDLE is accepted and clears data_available.
    exp_q.push_back({1'b0, cm_of(58)});
    pulse_start();
    chk("da_clear", data_available, 0);
    chk("busy_set", busy, 1);
    chk("trig_set", trig, 1);
    wait_for("trig_fall", 0, 1'b0, TRIG_US * C + 10);
    tick(100 * C);
    echo = 1'b1;
    tick(58 * C);
    echo = 1'b0;
    wait_for("idle", 1, 1'b0, (COOL_US + 50) * C);
    chk("sb_drain", exp_q.size(), 0);
    chk("two_trig", trig_pulses - p0, 2);
    $display("restart data=%0h", data);

    // Reset mid-MEASURE.
    pulse_start();
    wait_for("trig_rise", 0, 1'b1, 10);
    wait_for("trig_fall", 0, 1'b0, TRIG_US * C + 10);
    tick(50 * C);
    echo = 1'b1;
    tick(100 * C);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_trig", trig, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_data", data, 0);
    chk("mrst_da", data_available, 0);
    rst  = 1'b0;
    echo = 1'b0;
    tick(5);
    $display("mid_measure_reset data=%0h busy=%0b", data, busy);
    measure(150, 116);

    // Echo glitch during COOLDOWN leaves everything untouched.
    exp_q.push_back({1'b0, cm_of(290)});
    pulse_start();
    wait_for("trig_fall", 0, 1'b0, TRIG_US * C + 10);
    tick(100 * C);
    echo = 1'b1;
    tick(290 * C);
    echo = 1'b0;
    wait_for("da_rise", 2, 1'b1, 20);
    tick(4);
    echo = 1'b1;
    tick(3);
    echo = 1'b0;
    tick(10);
    chk("glitch_data", data, cm_of(290));
    chk("glitch_da", data_available, 1);
    chk("glitch_busy", busy, 1);
    wait_for("idle", 1, 1'b0, (COOL_US + 10) * C);
    chk("glitch_data_idle", data, cm_of(290));
    chk("glitch_da_idle", data_available, 1);
    chk("sb_drain", exp_q.size(), 0);
    $display("cooldown_glitch data=%0h da=%0b", data, data_available);

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
